serial_cmd_rx: RTL and testbench

SERIAL_CMD_RX -- requirements
Module: serial_cmd_rx

---
 rtl/serial_cmd_rx.sv | 207 ++++++++++++++++++++
 tb/tb_serial_cmd_rx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_cmd_rx.sv
// UART 8N1 byte receiver feeding a W/R command parser (opcode + 24-bit address [+ data]).
// Define SERIAL_CMD_RX_PARITY_EN for an 8E1 frame with an even-parity check.
module serial_cmd_rx #(
  parameter int CLK_HZ       = 25000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        cmd_wr,
  output logic        cmd_rd,
  output logic [23:0] cmd_addr,
  output logic [7:0]  cmd_data,
  output logic        busy
);

  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned HALF   = DIV / 2;
  localparam int unsigned TO_CYC = TIMEOUT_BITS * DIV;
  localparam int          CW     = $clog2(DIV + 1);
  localparam int          TW     = $clog2(TO_CYC + 1);

`ifdef SERIAL_CMD_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;
`endif

  typedef enum logic [2:0] {P_OP, P_A2, P_A1, P_A0, P_D} p_state_t;

  rx_state_t       state;
  p_state_t        pstate;
  logic            rx_s1, rx_s, rx_q;
  logic [CW-1:0]   cnt;
  logic [2:0]      bitcnt;
  logic [7:0]      shreg;
  logic            op_rd;
  logic [23:0]     shadow;
  logic [TW-1:0]   tcnt;
  logic            bit_done;
  logic            stop_ok;
`ifdef SERIAL_CMD_RX_PARITY_EN
  logic            par_err;
`endif

  always_ff @(posedge pixclk) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s  <= rx_s1;
      rx_q  <= rx_s;
    end
  end

  assign bit_done = (cnt == CW'(DIV - 1));
  assign busy     = (state != S_IDLE);

`ifdef SERIAL_CMD_RX_PARITY_EN
  assign stop_ok = rx_s && !par_err;
`else
  assign stop_ok = rx_s;
`endif

  // Byte receiver: start bit verified at mid-bit, then every DIV cycles lands mid-bit.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef SERIAL_CMD_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt    <= '0;
          bitcnt <= '0;
          if (rx_q && !rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt    <= '0;
            shreg  <= {rx_s, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
`ifdef SERIAL_CMD_RX_PARITY_EN
            if (bitcnt == 3'd7) state <= S_PARITY;
`else
            if (bitcnt == 3'd7) state <= S_STOP;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef SERIAL_CMD_RX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            cnt     <= '0;
            par_err <= ^{rx_s, shreg};
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (stop_ok) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address bytes collect in a shadow so an aborted command never disturbs cmd_addr.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      pstate   <= P_OP;
      op_rd    <= 1'b0;
      shadow   <= '0;
      tcnt     <= '0;
      cmd_wr   <= 1'b0;
      cmd_rd   <= 1'b0;
      cmd_addr <= '0;
      cmd_data <= '0;
    end else begin
      cmd_wr <= 1'b0;
      cmd_rd <= 1'b0;
      if (pstate == P_OP || rx_valid) tcnt <= '0;
      else                            tcnt <= tcnt + TW'(1);

      if (frame_err) begin
        pstate <= P_OP;
      end else if (rx_valid) begin
        case (pstate)
          P_OP: begin
            if (rx_data == 8'h57) begin
              op_rd  <= 1'b0;
              pstate <= P_A2;
            end else if (rx_data == 8'h52) begin
              op_rd  <= 1'b1;
              pstate <= P_A2;
            end
          end
          P_A2: begin
            shadow[23:16] <= rx_data;
            pstate        <= P_A1;
          end
          P_A1: begin
            shadow[15:8] <= rx_data;
            pstate       <= P_A0;
          end
          P_A0: begin
            shadow[7:0] <= rx_data;
            if (op_rd) begin
              cmd_addr <= {shadow[23:8], rx_data};
              cmd_rd   <= 1'b1;
              pstate   <= P_OP;
            end else begin
              pstate <= P_D;
            end
          end
          P_D: begin
            cmd_addr <= shadow;
            cmd_data <= rx_data;
            cmd_wr   <= 1'b1;
            pstate   <= P_OP;
          end
          default: pstate <= P_OP;
        endcase
      end else if (pstate != P_OP && tcnt == TW'(TO_CYC - 1)) begin
        pstate <= P_OP;
      end
    end
  end

endmodule

// File: tb/tb_serial_cmd_rx.sv
// Directed self-checking bench for serial_cmd_rx at default parameters (DIV = 217).
module tb_serial_cmd_rx;

  localparam int DIV = 217;

  logic        pixclk = 1'b0;
  logic        reset;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        cmd_wr;
  logic        cmd_rd;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        busy;

  int checks = 0;
  int passed = 0;

  int   rv_cnt = 0, fe_cnt = 0, wr_cnt = 0, rd_cnt = 0, viol = 0, lat_err = 0;
  logic prev_rv = 1'b0, prev_fe = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;

  serial_cmd_rx #(
    .CLK_HZ       (25000000),
    .BAUD         (115200),
    .TIMEOUT_BITS (20)
  ) dut (
    .pixclk    (pixclk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .cmd_wr    (cmd_wr),
    .cmd_rd    (cmd_rd),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .busy      (busy)
  );

  always #5 pixclk = ~pixclk;

  // Pulse counters plus strobe-width, exclusivity and latency bookkeeping.
  always @(negedge pixclk) begin
    if (rx_valid)  rv_cnt++;
    if (frame_err) fe_cnt++;
    if (cmd_wr)    wr_cnt++;
    if (cmd_rd)    rd_cnt++;
    if ((rx_valid && prev_rv) || (frame_err && prev_fe) ||
        (cmd_wr && prev_wr) || (cmd_rd && prev_rd) || (cmd_wr && cmd_rd)) viol++;
    if ((cmd_wr || cmd_rd) && !prev_rv) lat_err++;
    prev_rv = rx_valid;
    prev_fe = frame_err;
    prev_wr = cmd_wr;
    prev_rd = cmd_rd;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge pixclk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (DIV) @(negedge pixclk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef SERIAL_CMD_RX_PARITY_EN
    send_bit(^b);
`endif
    send_bit(stop_bit);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rx    = 1'b1;
    repeat (4) @(negedge pixclk);
    checks++;
    if ({rx_valid, frame_err, cmd_wr, cmd_rd, busy} !== 5'b0)
      $display("FAIL reset_strobes: got %b expected 00000", {rx_valid, frame_err, cmd_wr, cmd_rd, busy});
    else passed++;
    checks++;
    if ({rx_data, cmd_data} !== 16'h0000)
      $display("FAIL reset_data: got %h expected 0000", {rx_data, cmd_data});
    else passed++;
    checks++;
    if (cmd_addr !== 24'h0) $display("FAIL reset_addr: got %h expected 000000", cmd_addr);
    else passed++;
    reset = 1'b1;
    idle(DIV);
  endtask

  task automatic test_byte;
    int rv0 = rv_cnt, fe0 = fe_cnt;
    send_byte(8'hA5, 1'b1);
    idle(20);
    checks++;
    if (rv_cnt - rv0 !== 1) $display("FAIL byte_valid_count: got %0d expected 1", rv_cnt - rv0);
    else passed++;
    checks++;
    if (rx_data !== 8'hA5) $display("FAIL byte_data: got %h expected a5", rx_data);
    else passed++;
    checks++;
    if (fe_cnt - fe0 !== 0) $display("FAIL byte_frame_err: got %0d expected 0", fe_cnt - fe0);
    else passed++;
  endtask

  task automatic test_write;
    int wr0 = wr_cnt, rd0 = rd_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'hAB, 1'b1);
    idle(20);
    checks++;
    if (wr_cnt - wr0 !== 1) $display("FAIL write_wr_count: got %0d expected 1", wr_cnt - wr0);
    else passed++;
    checks++;
    if (rd_cnt - rd0 !== 0) $display("FAIL write_rd_count: got %0d expected 0", rd_cnt - rd0);
    else passed++;
    checks++;
    if (cmd_addr !== 24'h123456) $display("FAIL write_addr: got %h expected 123456", cmd_addr);
    else passed++;
    checks++;
    if (cmd_data !== 8'hAB) $display("FAIL write_data: got %h expected ab", cmd_data);
    else passed++;
  endtask

  task automatic test_read;
    int wr0 = wr_cnt, rd0 = rd_cnt;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b1);
    idle(20);
    checks++;
    if (rd_cnt - rd0 !== 1) $display("FAIL read_rd_count: got %0d expected 1", rd_cnt - rd0);
    else passed++;
    checks++;
    if (wr_cnt - wr0 !== 0) $display("FAIL read_wr_count: got %0d expected 0", wr_cnt - wr0);
    else passed++;
    checks++;
    if (cmd_addr !== 24'h0001FF) $display("FAIL read_addr: got %h expected 0001ff", cmd_addr);
    else passed++;
    checks++;
    if (cmd_data !== 8'hAB) $display("FAIL read_data_held: got %h expected ab", cmd_data);
    else passed++;
  endtask

  task automatic test_frame_err;
    int rv0 = rv_cnt, fe0 = fe_cnt, wr0 = wr_cnt;
    send_byte(8'h3C, 1'b0);
    idle(DIV);
    checks++;
    if (fe_cnt - fe0 !== 1) $display("FAIL frame_err_count: got %0d expected 1", fe_cnt - fe0);
    else passed++;
    checks++;
    if (rx_data !== 8'hAB && rx_data !== 8'hFF) $display("FAIL frame_rx_data_held: got %h expected ff", rx_data);
    else passed++;
    send_byte(8'h57, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h07, 1'b1);
    idle(20);
    checks++;
    if (rv_cnt - rv0 !== 5) $display("FAIL frame_valid_count: got %0d expected 5", rv_cnt - rv0);
    else passed++;
    checks++;
    if (wr_cnt - wr0 !== 1 || cmd_addr !== 24'h000001 || cmd_data !== 8'h07)
      $display("FAIL frame_then_write: got wr=%0d addr=%h data=%h expected wr=1 addr=000001 data=07",
               wr_cnt - wr0, cmd_addr, cmd_data);
    else passed++;
  endtask

  task automatic test_timeout;
    int wr0 = wr_cnt, rd0 = rd_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'hAA, 1'b1);
    idle(25 * DIV);
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    idle(20);
    checks++;
    if (wr_cnt - wr0 !== 0) $display("FAIL timeout_wr_count: got %0d expected 0", wr_cnt - wr0);
    else passed++;
    checks++;
    if (rd_cnt - rd0 !== 1) $display("FAIL timeout_rd_count: got %0d expected 1", rd_cnt - rd0);
    else passed++;
    checks++;
    if (cmd_addr !== 24'h000010) $display("FAIL timeout_addr: got %h expected 000010", cmd_addr);
    else passed++;
  endtask

  task automatic test_glitch;
    int rv0 = rv_cnt, fe0 = fe_cnt;
    idle(DIV);
    rx = 1'b0;
    repeat (2) @(negedge pixclk);
    rx = 1'b1;
    repeat (5) @(negedge pixclk);
    checks++;
    if (busy !== 1'b1) $display("FAIL glitch_busy_high: got %b expected 1", busy);
    else passed++;
    idle(DIV);
    checks++;
    if (busy !== 1'b0) $display("FAIL glitch_busy_low: got %b expected 0", busy);
    else passed++;
    checks++;
    if (rv_cnt - rv0 !== 0 || fe_cnt - fe0 !== 0)
      $display("FAIL glitch_strobes: got rv=%0d fe=%0d expected rv=0 fe=0", rv_cnt - rv0, fe_cnt - fe0);
    else passed++;
  endtask

  task automatic test_mid_reset;
    int rd0;
    send_byte(8'h52, 1'b1);
    send_byte(8'h11, 1'b1);
    idle(10);
    reset = 1'b0;
    @(negedge pixclk);
    reset = 1'b1;
    checks++;
    if ({rx_valid, frame_err, cmd_wr, cmd_rd, busy} !== 5'b0 || rx_data !== 8'h00)
      $display("FAIL midreset_outputs: got strobes=%b rx_data=%h expected 00000/00",
               {rx_valid, frame_err, cmd_wr, cmd_rd, busy}, rx_data);
    else passed++;
    checks++;
    if (cmd_addr !== 24'h0 || cmd_data !== 8'h0)
      $display("FAIL midreset_cmd: got addr=%h data=%h expected 000000/00", cmd_addr, cmd_data);
    else passed++;
    idle(DIV);
    rd0 = rd_cnt;
    send_byte(8'h52, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(20);
    checks++;
    if (rd_cnt - rd0 !== 1) $display("FAIL midreset_rd_count: got %0d expected 1", rd_cnt - rd0);
    else passed++;
    checks++;
    if (cmd_addr !== 24'h000002) $display("FAIL midreset_addr: got %h expected 000002", cmd_addr);
    else passed++;
  endtask

`ifdef SERIAL_CMD_RX_PARITY_EN
  task automatic test_parity;
    int rv0 = rv_cnt, fe0 = fe_cnt;
    logic [7:0] b = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b));
    send_bit(1'b1);
    idle(20);
    checks++;
    if (fe_cnt - fe0 !== 1 || rv_cnt - rv0 !== 0)
      $display("FAIL parity_err: got fe=%0d rv=%0d expected fe=1 rv=0", fe_cnt - fe0, rv_cnt - rv0);
    else passed++;
  endtask
`endif

  task automatic test_strobe_rules;
    checks++;
    if (viol !== 0) $display("FAIL strobe_width_excl: got %0d expected 0", viol);
    else passed++;
    checks++;
    if (lat_err !== 0) $display("FAIL cmd_latency: got %0d expected 0", lat_err);
    else passed++;
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    test_reset();
    test_byte();
    test_write();
    test_read();
    test_frame_err();
    test_timeout();
    test_glitch();
    test_mid_reset();
`ifdef SERIAL_CMD_RX_PARITY_EN
    test_parity();
`endif
    test_strobe_rules();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
